// File: rtl/mem_controller.sv
// Byte-wide RAM port arbiter/serialiser for icache word fetches and LSU loads/stores.
// Optional MEMCON_IO_STALL_EN holds write beats to I/O space while io_buffer_full is high.
module mem_controller #(
    parameter int                ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(32'h30000)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full,
    input  logic              icache2memCon_enable,
    input  logic [ADDR_W-1:0] icache2memCon_addr,
    output logic              memCon2icache_enable,
    output logic [31:0]       memCon2icache_return,
    input  logic              lsu2memCon_enable,
    input  logic              lsu2memCon_rw,
    input  logic [1:0]        lsu2memCon_width,
    input  logic [ADDR_W-1:0] lsu2memCon_addr,
    input  logic [31:0]       lsu2memCon_value,
    input  logic              lsu2memCon_ifSigned,
    output logic              memCon2lsu_enable,
    output logic [31:0]       memCon2lsu_return,
    input  logic              rob2memCon_clear
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_reg, state_next;
    logic              owner_lsu_reg;
    logic              rw_reg;
    logic              signed_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [2:0]        nbytes_reg;
    logic [2:0]        issue_cnt_reg;
    logic [31:0]       value_reg;
    logic              rd_pend_reg;
    logic [1:0]        cap_lane_reg;

    logic              grant_lsu, grant_ic, grant;
    logic [2:0]        lsu_nbytes;
    logic [ADDR_W-1:0] beat_addr, cap_addr;
    logic              issuing, io_hold, do_issue;
    logic              last_issue, last_capture, abort;
    logic [31:0]       rd_data;
    logic [31:0]       load_ext;

    always_comb begin
        grant_lsu = 1'b0;
        grant_ic  = 1'b0;
        if (state_reg == IDLE && !rob2memCon_clear) begin
            if (lsu2memCon_enable)
                grant_lsu = 1'b1;
            else if (icache2memCon_enable)
                grant_ic = 1'b1;
        end
    end

    assign grant = grant_lsu | grant_ic;

    always_comb begin
        case (lsu2memCon_width)
            2'd0:    lsu_nbytes = 3'd1;
            2'd1:    lsu_nbytes = 3'd2;
            default: lsu_nbytes = 3'd4;
        endcase
    end

    assign beat_addr = addr_reg + ADDR_W'(issue_cnt_reg);
    assign cap_addr  = addr_reg + ADDR_W'(cap_lane_reg);
    assign issuing   = (state_reg == BUSY) && (issue_cnt_reg < nbytes_reg);

`ifdef MEMCON_IO_STALL_EN
    assign io_hold = rw_reg && io_buffer_full && (beat_addr >= IO_BASE);
`else
    logic io_unused;
    assign io_unused = io_buffer_full ^ (IO_BASE != '0);
    assign io_hold   = 1'b0;
`endif

    assign do_issue     = issuing && !io_hold;
    assign last_issue   = do_issue && (issue_cnt_reg == nbytes_reg - 3'd1);
    assign last_capture = rd_pend_reg && ({1'b0, cap_lane_reg} == nbytes_reg - 3'd1);
    // Committed stores are never abandoned; only reads can be flushed.
    assign abort        = rob2memCon_clear && !rw_reg;

    always_ff @(posedge clk_in) begin
        if (rst_in)
            state_reg <= IDLE;
        else if (rdy_in)
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (grant) state_next = BUSY;
            BUSY: begin
                if (abort)
                    state_next = IDLE;
                else if (rw_reg ? last_issue : last_capture)
                    state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            owner_lsu_reg <= 1'b0;
            rw_reg        <= 1'b0;
            signed_reg    <= 1'b0;
            addr_reg      <= '0;
            nbytes_reg    <= 3'd0;
            issue_cnt_reg <= 3'd0;
            value_reg     <= 32'd0;
            rd_pend_reg   <= 1'b0;
            cap_lane_reg  <= 2'd0;
        end else if (rdy_in) begin
            if (grant_lsu) begin
                owner_lsu_reg <= 1'b1;
                rw_reg        <= lsu2memCon_rw;
                signed_reg    <= lsu2memCon_ifSigned;
                addr_reg      <= lsu2memCon_addr;
                nbytes_reg    <= lsu_nbytes;
                value_reg     <= lsu2memCon_value;
            end else if (grant_ic) begin
                owner_lsu_reg <= 1'b0;
                rw_reg        <= 1'b0;
                signed_reg    <= 1'b0;
                addr_reg      <= icache2memCon_addr;
                nbytes_reg    <= 3'd4;
                value_reg     <= 32'd0;
            end
            if (grant) begin
                issue_cnt_reg <= 3'd0;
                rd_pend_reg   <= 1'b0;
            end else if (state_reg == BUSY) begin
                // rd_pend marks that mem_din carries the byte issued last cycle.
                rd_pend_reg <= do_issue && !rw_reg;
                if (do_issue) begin
                    issue_cnt_reg <= issue_cnt_reg + 3'd1;
                    cap_lane_reg  <= issue_cnt_reg[1:0];
                end
            end else begin
                rd_pend_reg <= 1'b0;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] byte_reg;
            always_ff @(posedge clk_in) begin
                if (rst_in)
                    byte_reg <= 8'd0;
                else if (rdy_in && state_reg == BUSY && rd_pend_reg && cap_lane_reg == 2'(gi))
                    byte_reg <= mem_din;
            end
            assign rd_data[8*gi +: 8] = byte_reg;
        end
    endgenerate

    always_comb begin
        load_ext = rd_data;
        case (nbytes_reg)
            3'd1:    load_ext = {{24{signed_reg & rd_data[7]}}, rd_data[7:0]};
            3'd2:    load_ext = {{16{signed_reg & rd_data[15]}}, rd_data[15:0]};
            default: load_ext = rd_data;
        endcase
    end

    always_comb begin
        mem_a                = '0;
        mem_dout             = 8'd0;
        mem_wr               = 1'b0;
        memCon2icache_enable = 1'b0;
        memCon2icache_return = 32'd0;
        memCon2lsu_enable    = 1'b0;
        memCon2lsu_return    = 32'd0;
        case (state_reg)
            BUSY: begin
                // While frozen, re-present the pending read address so mem_din
                // still holds that byte when the pipeline resumes.
                if (issuing && !(rd_pend_reg && !rdy_in))
                    mem_a = beat_addr;
                else
                    mem_a = cap_addr;
                if (rw_reg && issuing)
                    mem_dout = value_reg[8*issue_cnt_reg[1:0] +: 8];
                mem_wr = rw_reg && do_issue && rdy_in;
            end
            DONE: begin
                if (owner_lsu_reg) begin
                    memCon2lsu_enable = 1'b1;
                    memCon2lsu_return = rw_reg ? 32'd0 : load_ext;
                end else begin
                    memCon2icache_enable = 1'b1;
                    memCon2icache_return = rd_data;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_controller.sv
// Scoreboard bench for mem_controller: directed scenarios plus random traffic
// checked against a byte-array memory model.
module tb_mem_controller;

`ifdef MEMCON_IO_STALL_EN
    localparam int IO_STALL = 3;
`else
    localparam int IO_STALL = 0;
`endif
    localparam int NSLOT = 1537;

    logic        clk_in, rst_in, rdy_in;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr, io_buffer_full;
    logic        icache2memCon_enable, memCon2icache_enable;
    logic [31:0] icache2memCon_addr, memCon2icache_return;
    logic        lsu2memCon_enable, lsu2memCon_rw, lsu2memCon_ifSigned;
    logic [1:0]  lsu2memCon_width;
    logic [31:0] lsu2memCon_addr, lsu2memCon_value;
    logic        memCon2lsu_enable;
    logic [31:0] memCon2lsu_return;
    logic        rob2memCon_clear;

    mem_controller dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full),
        .icache2memCon_enable(icache2memCon_enable), .icache2memCon_addr(icache2memCon_addr),
        .memCon2icache_enable(memCon2icache_enable), .memCon2icache_return(memCon2icache_return),
        .lsu2memCon_enable(lsu2memCon_enable), .lsu2memCon_rw(lsu2memCon_rw),
        .lsu2memCon_width(lsu2memCon_width), .lsu2memCon_addr(lsu2memCon_addr),
        .lsu2memCon_value(lsu2memCon_value), .lsu2memCon_ifSigned(lsu2memCon_ifSigned),
        .memCon2lsu_enable(memCon2lsu_enable), .memCon2lsu_return(memCon2lsu_return),
        .rob2memCon_clear(rob2memCon_clear)
    );

    typedef struct { bit lsu; logic [31:0] val; int cyc; } exp_t;
    typedef struct { int cyc; logic [31:0] a; bit wr; logic [7:0] d; } beat_t;

    exp_t        exp_q[$];
    beat_t       beat_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    bit          bus_chk_off = 0;
    bit          seen_lsu, seen_ic;
    logic [7:0]  dev_ram [NSLOT];
    logic [7:0]  ref_ram [NSLOT];

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    always @(posedge clk_in) cyc <= cyc + 1;

    function automatic int idx_of(input logic [31:0] a);
        if (a < 32'd1024) return int'(a);
        if (a >= 32'h30000 && a < 32'h30100) return 1024 + int'(a - 32'h30000);
        if (a >= 32'hFFFFFF00) return 1280 + int'(a - 32'hFFFFFF00);
        return 1536;
    endfunction

    function automatic logic [7:0] pat(input int i);
        return 8'((i * 37 + 11) ^ (i >> 3));
    endfunction

    // RAM device on the bus: read data appears the cycle after the address.
    always @(posedge clk_in) begin
        if (cyc == 0) begin
            for (int i = 0; i < NSLOT; i++) dev_ram[i] <= pat(i);
        end else if (mem_wr) begin
            dev_ram[idx_of(mem_a)] <= mem_dout;
        end
        mem_din <= dev_ram[idx_of(mem_a)];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: expected bus beats, memory effect and done pulse of one request.
    task automatic plan(input bit lsu, input bit wr, input int n, input logic [31:0] a,
                        input logic [31:0] v, input bit s, input int k, input int extra,
                        input int nbeats, input bit push_exp);
        exp_t e;
        beat_t b;
        logic [31:0] val;
        val = 32'd0;
        for (int i = 0; i < nbeats; i++) begin
            b.cyc = k + 1 + i;
            b.a   = a + 32'(i);
            b.wr  = wr;
            b.d   = wr ? 8'(v >> (8 * i)) : 8'h00;
            beat_q.push_back(b);
        end
        if (push_exp) begin
            if (wr) begin
                for (int i = 0; i < n; i++) ref_ram[idx_of(a + 32'(i))] = 8'(v >> (8 * i));
            end else begin
                for (int i = 0; i < n; i++)
                    val = val + (32'(ref_ram[idx_of(a + 32'(i))]) << (8 * i));
                if (s && n == 1 && val >= 32'd128)   val = val + 32'hFFFFFF00;
                if (s && n == 2 && val >= 32'd32768) val = val + 32'hFFFF0000;
            end
            e.lsu = lsu;
            e.val = val;
            e.cyc = k + n + (wr ? 1 : 2) + extra;
            exp_q.push_back(e);
        end
    endtask

    function automatic int nbytes_of(input logic [1:0] wc);
        return (wc == 2'd0) ? 1 : (wc == 2'd1) ? 2 : 4;
    endfunction

    task automatic step();
        @(negedge clk_in);
        if (memCon2lsu_enable) begin lsu2memCon_enable = 1'b0; seen_lsu = 1'b1; end
        if (memCon2icache_enable) begin icache2memCon_enable = 1'b0; seen_ic = 1'b1; end
    endtask

    task automatic raise_lsu(input bit wr, input logic [1:0] wc, input logic [31:0] a,
                             input logic [31:0] v, input bit s);
        lsu2memCon_rw = wr; lsu2memCon_width = wc; lsu2memCon_addr = a;
        lsu2memCon_value = v; lsu2memCon_ifSigned = s;
        lsu2memCon_enable = 1'b1; seen_lsu = 1'b0;
    endtask

    task automatic raise_ic(input logic [31:0] a);
        icache2memCon_addr = a; icache2memCon_enable = 1'b1; seen_ic = 1'b0;
    endtask

    task automatic wait_done(input bit lsu);
        for (int t = 0; t < 200; t++) begin
            if (lsu ? seen_lsu : seen_ic) break;
            step();
        end
        if (!(lsu ? seen_lsu : seen_ic)) begin
            checks++; failures++;
            $display("FAIL timeout waiting for %s done", lsu ? "lsu" : "icache");
            lsu2memCon_enable = 1'b0; icache2memCon_enable = 1'b0;
        end
    endtask

    task automatic xact(input bit lsu, input bit wr, input logic [1:0] wc,
                        input logic [31:0] a, input logic [31:0] v, input bit s);
        int k;
        step();
        k = cyc;
        if (lsu) begin
            plan(1'b1, wr, nbytes_of(wc), a, v, s, k, 0, nbytes_of(wc), 1'b1);
            raise_lsu(wr, wc, a, v, s);
        end else begin
            plan(1'b0, 1'b0, 4, a, 32'd0, 1'b0, k, 0, 4, 1'b1);
            raise_ic(a);
        end
        wait_done(lsu);
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
        if (r == 1) return 32'h30000 + 32'($urandom_range(0, 200));
        return 32'($urandom_range(0, 1000));
    endfunction

    // Monitor: pops expected beats and done pulses as the DUT presents them.
    initial begin
        exp_t e;
        beat_t b;
        forever begin
            @(negedge clk_in);
            if (memCon2lsu_enable || memCon2icache_enable) begin
                chk("both_enables", 32'(memCon2lsu_enable & memCon2icache_enable), 32'd0);
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_done lsu=%0b icache=%0b at cycle %0d",
                             memCon2lsu_enable, memCon2icache_enable, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_owner", 32'(memCon2lsu_enable), 32'(e.lsu));
                    chk("done_cycle", cyc, e.cyc);
                    chk("done_return", e.lsu ? memCon2lsu_return : memCon2icache_return, e.val);
                    chk("done_memwr", 32'(mem_wr), 32'd0);
                end
            end
            if (beat_q.size() > 0 && beat_q[0].cyc <= cyc) begin
                b = beat_q.pop_front();
                chk("beat_addr", mem_a, b.a);
                chk("beat_wr", 32'(mem_wr), 32'(b.wr));
                if (b.wr) chk("beat_data", 32'(mem_dout), 32'(b.d));
            end else if (mem_wr && !bus_chk_off) begin
                chk("unexpected_write", 32'(mem_wr), 32'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k, d, bad;
        rst_in = 1'b1; rdy_in = 1'b1; io_buffer_full = 1'b0; rob2memCon_clear = 1'b0;
        icache2memCon_enable = 1'b0; icache2memCon_addr = 32'd0;
        lsu2memCon_enable = 1'b1; lsu2memCon_rw = 1'b1; lsu2memCon_width = 2'd2;
        lsu2memCon_addr = 32'h10; lsu2memCon_value = 32'h12345678; lsu2memCon_ifSigned = 1'b0;
        seen_lsu = 1'b0; seen_ic = 1'b0;
        for (int i = 0; i < NSLOT; i++) ref_ram[i] = pat(i);

        repeat (4) @(negedge clk_in);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_dout", 32'(mem_dout), 32'd0);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_lsu_en", 32'(memCon2lsu_enable), 32'd0);
        chk("rst_ic_en", 32'(memCon2icache_enable), 32'd0);
        chk("rst_lsu_ret", memCon2lsu_return, 32'd0);
        chk("rst_ic_ret", memCon2icache_return, 32'd0);
        lsu2memCon_enable = 1'b0;
        rst_in = 1'b0;

        // Fetch of 13 05 00 00; byte/half sign handling; SW then LW.
        xact(1, 1, 2'd2, 32'h100, 32'h00000513, 0);
        xact(0, 0, 2'd2, 32'h100, 32'd0, 0);
        xact(1, 1, 2'd0, 32'h20, 32'h00000080, 0);
        xact(1, 0, 2'd0, 32'h20, 32'd0, 1);
        xact(1, 0, 2'd0, 32'h20, 32'd0, 0);
        xact(1, 1, 2'd1, 32'h20, 32'h0000FF80, 0);
        xact(1, 0, 2'd1, 32'h20, 32'd0, 1);
        xact(1, 1, 2'd2, 32'h40, 32'hDEADBEEF, 0);
        xact(1, 0, 2'd2, 32'h40, 32'd0, 0);

        // Simultaneous requests: LSU first, icache the cycle after LSU DONE.
        step(); k = cyc;
        plan(1, 0, 2, 32'h20, 32'd0, 1, k, 0, 2, 1);
        raise_lsu(0, 2'd1, 32'h20, 32'd0, 1);
        raise_ic(32'h100);
        wait_done(1);
        d = cyc;
        plan(0, 0, 4, 32'h100, 32'd0, 0, d + 1, 0, 4, 1);
        wait_done(0);

        // Clear during beat 2 of a fetch, then a fresh fetch granted straight from IDLE.
        step(); k = cyc;
        plan(0, 0, 4, 32'h200, 32'd0, 0, k, 0, 3, 0);
        raise_ic(32'h200);
        step(); step(); step();
        rob2memCon_clear = 1'b1; icache2memCon_addr = 32'h104;
        step();
        rob2memCon_clear = 1'b0; k = cyc;
        plan(0, 0, 4, 32'h104, 32'd0, 0, k, 0, 4, 1);
        wait_done(0);

        // Clear during a store: all beats still written, done still pulses.
        step(); k = cyc;
        plan(1, 1, 4, 32'h300, 32'hCAFEF00D, 0, k, 0, 4, 1);
        raise_lsu(1, 2'd2, 32'h300, 32'hCAFEF00D, 0);
        step(); step();
        rob2memCon_clear = 1'b1;
        step();
        rob2memCon_clear = 1'b0;
        wait_done(1);
        xact(1, 0, 2'd2, 32'h300, 32'd0, 0);

        // Clear in IDLE blocks that edge's grant.
        step();
        raise_lsu(0, 2'd2, 32'h100, 32'd0, 0);
        rob2memCon_clear = 1'b1;
        step();
        rob2memCon_clear = 1'b0; k = cyc;
        plan(1, 0, 4, 32'h100, 32'd0, 0, k, 0, 4, 1);
        wait_done(1);

        // Store into I/O space with the UART buffer full for three cycles.
        bus_chk_off = 1'b1;
        step(); k = cyc;
        plan(1, 1, 1, 32'h30000, 32'h5A, 0, k, IO_STALL, 0, 1);
        raise_lsu(1, 2'd0, 32'h30000, 32'h5A, 0);
        io_buffer_full = 1'b1;
        for (int t = 1; t <= 3; t++) begin
            step();
            chk("io_hold_wr", 32'(mem_wr), (IO_STALL == 0 && t == 1) ? 32'd1 : 32'd0);
        end
        step();
        io_buffer_full = 1'b0;
        wait_done(1);

        // rdy_in low for two cycles in the middle of a word read.
        step(); k = cyc;
        plan(1, 0, 4, 32'h40, 32'd0, 0, k, 2, 0, 1);
        raise_lsu(0, 2'd2, 32'h40, 32'd0, 0);
        step(); step();
        rdy_in = 1'b0;
        step(); step();
        rdy_in = 1'b1;
        wait_done(1);
        bus_chk_off = 1'b0;

        for (int t = 0; t < 200; t++) begin
            int kind;
            kind = $urandom_range(0, 3);
            if (kind == 0)
                xact(0, 0, 2'd2, rand_addr(), 32'd0, 0);
            else
                xact(1, kind == 3, 2'($urandom_range(0, 3)), rand_addr(), $urandom,
                     1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) step();
        end

        repeat (4) step();
        chk("exp_queue_drained", exp_q.size(), 32'd0);
        chk("beat_queue_drained", beat_q.size(), 32'd0);
        bad = 0;
        for (int i = 0; i < NSLOT; i++) begin
            if (dev_ram[i] !== ref_ram[i]) begin
                if (bad < 4)
                    $display("FAIL ram_contents slot=%0d actual=%h required=%h", i, dev_ram[i], ref_ram[i]);
                bad++;
            end
        end
        chk("ram_mismatch_count", bad, 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
